// File: rtl/mem_port_arb.sv
// Round-robin arbiter for four requesters sharing one fixed-latency memory port.
// Ports:
//   i_clk    sole clock, rising edge
//   i_rst    synchronous active-high reset
//   i_req    per-requester request, held until that requester's ACK
//   o_sel    encoded index of the current or last grantee (address/data mux select)
//   o_gnt    one-hot grant, held for the whole transaction
//   o_mem_en one-cycle memory strobe per transaction
//   o_ack    one-hot, one-cycle completion pulse, LAT cycles after o_mem_en
//   o_busy   high while a transaction is outstanding
module mem_port_arb #(
    parameter int LAT = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_req,
    output logic [1:0] o_sel,
    output logic [3:0] o_gnt,
    output logic       o_mem_en,
    output logic [3:0] o_ack,
    output logic       o_busy
);

    if (LAT < 1 || LAT > 8) begin : g_bad_lat
        $error("mem_port_arb: LAT must be in 1..8");
    end

    localparam logic [3:0] LAT_W = 4'(LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [3:0] r_cnt;
    logic [1:0] r_sel;
    logic [3:0] r_gnt;
    logic       r_mem_en;
    logic [3:0] r_ack;
    logic       r_busy;

    logic [3:0] w_cand;
    logic       w_found;
    logic [1:0] w_win;
    logic [3:0] w_win_oh;

    // Candidates for the next grant. The only WAIT cycle in which the result
    // is used is the ACK cycle, where the requester just served is excluded
    // so a held REQ cannot win twice in a row.
    always_comb begin
        w_cand = i_req;
        if (r_state == S_WAIT) begin
            w_cand = i_req & ~r_gnt;
        end
    end

    // First set candidate in rotating order starting at r_ptr.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int k = 0; k < 4; k++) begin
            if (!w_found && w_cand[r_ptr + 2'(k)]) begin
                w_found = 1'b1;
                w_win   = r_ptr + 2'(k);
            end
        end
    end

    assign w_win_oh = 4'b0001 << w_win;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= 2'd0;
            r_cnt    <= 4'd0;
            r_sel    <= 2'd0;
            r_gnt    <= 4'd0;
            r_mem_en <= 1'b0;
            r_ack    <= 4'd0;
            r_busy   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state  <= S_ISSUE;
                        r_gnt    <= w_win_oh;
                        r_sel    <= w_win;
                        r_ptr    <= w_win + 2'd1;
                        r_mem_en <= 1'b1;
                        r_busy   <= 1'b1;
                        r_cnt    <= LAT_W;
                    end
                end
                S_ISSUE: begin
                    r_state  <= S_WAIT;
                    r_mem_en <= 1'b0;
                    r_cnt    <= r_cnt - 4'd1;
                    // With LAT=1 the ACK follows the strobe directly.
                    if (r_cnt == 4'd1) begin
                        r_ack <= r_gnt;
                    end
                end
                S_WAIT: begin
                    if (r_ack != 4'd0) begin
                        // ACK cycle doubles as the next arbitration point.
                        r_ack <= 4'd0;
                        if (w_found) begin
                            r_state  <= S_ISSUE;
                            r_gnt    <= w_win_oh;
                            r_sel    <= w_win;
                            r_ptr    <= w_win + 2'd1;
                            r_mem_en <= 1'b1;
                            r_cnt    <= LAT_W;
                        end else begin
                            r_state <= S_IDLE;
                            r_gnt   <= 4'd0;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        if (r_cnt != 4'd0) begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                        if (r_cnt == 4'd1) begin
                            r_ack <= r_gnt;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_sel    = r_sel;
    assign o_gnt    = r_gnt;
    assign o_mem_en = r_mem_en;
    assign o_ack    = r_ack;
    assign o_busy   = r_busy;

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: three instances (LAT=1,3,4) against a
// transaction-age reference model, directed scenarios then random traffic.
module tb_mem_port_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst    [3];
    logic [3:0] req    [3];
    logic [1:0] sel    [3];
    logic [3:0] gnt    [3];
    logic       mem_en [3];
    logic [3:0] ack    [3];
    logic       busy   [3];

    mem_port_arb #(.LAT(1)) u_l1 (
        .i_clk(clk), .i_rst(rst[0]), .i_req(req[0]),
        .o_sel(sel[0]), .o_gnt(gnt[0]), .o_mem_en(mem_en[0]),
        .o_ack(ack[0]), .o_busy(busy[0])
    );
    mem_port_arb #(.LAT(3)) u_l3 (
        .i_clk(clk), .i_rst(rst[1]), .i_req(req[1]),
        .o_sel(sel[1]), .o_gnt(gnt[1]), .o_mem_en(mem_en[1]),
        .o_ack(ack[1]), .o_busy(busy[1])
    );
    mem_port_arb #(.LAT(4)) u_l4 (
        .i_clk(clk), .i_rst(rst[2]), .i_req(req[2]),
        .o_sel(sel[2]), .o_gnt(gnt[2]), .o_mem_en(mem_en[2]),
        .o_ack(ack[2]), .o_busy(busy[2])
    );

    int lats   [3];
    int m_busy [3];
    int m_g    [3];
    int m_age  [3];
    int m_ptr  [3];
    int m_sel  [3];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [3:0] obs,
                       input logic [3:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: a transaction is "age" cycles past its strobe; it completes at
    // age==LAT, and arbitration happens when idle or at completion.
    task automatic model_step(input int i);
        logic [3:0] cand;
        int c;
        if (rst[i]) begin
            m_busy[i] = 0; m_g[i] = 0; m_age[i] = 0;
            m_ptr[i] = 0; m_sel[i] = 0;
        end else if (m_busy[i] == 0 || m_age[i] == lats[i]) begin
            cand = req[i];
            if (m_busy[i] != 0) cand[m_g[i]] = 1'b0;
            m_busy[i] = 0;
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr[i] + k) % 4;
                if (m_busy[i] == 0 && cand[c]) begin
                    m_busy[i] = 1; m_g[i] = c;
                    m_sel[i] = c; m_age[i] = 0;
                end
            end
            if (m_busy[i] != 0) m_ptr[i] = (m_g[i] + 1) % 4;
        end else begin
            m_age[i]++;
        end
    endtask

    task automatic cmp_model(input int i);
        logic [3:0] eg, ea;
        logic em, eb;
        eb = (m_busy[i] != 0);
        eg = eb ? 4'(1 << m_g[i]) : 4'b0;
        ea = (eb && m_age[i] == lats[i]) ? eg : 4'b0;
        em = eb && m_age[i] == 0;
        chk($sformatf("M%0d.gnt", i), gnt[i], eg);
        chk($sformatf("M%0d.ack", i), ack[i], ea);
        chk($sformatf("M%0d.mem_en", i), {3'b0, mem_en[i]}, {3'b0, em});
        chk($sformatf("M%0d.busy", i), {3'b0, busy[i]}, {3'b0, eb});
        chk($sformatf("M%0d.sel", i), {2'b0, sel[i]}, 4'(m_sel[i]));
    endtask

    task automatic cyc();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        @(negedge clk);
        for (int i = 0; i < 3; i++) cmp_model(i);
    endtask

    task automatic chk_zero(input string tag, input int i);
        chk({tag, ".gnt"}, gnt[i], 4'b0);
        chk({tag, ".ack"}, ack[i], 4'b0);
        chk({tag, ".mem_en"}, {3'b0, mem_en[i]}, 4'b0);
        chk({tag, ".busy"}, {3'b0, busy[i]}, 4'b0);
        chk({tag, ".sel"}, {2'b0, sel[i]}, 4'b0);
    endtask

    initial begin
        lats[0] = 1; lats[1] = 3; lats[2] = 4;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; req[i] = 4'b0;
            m_busy[i] = 0; m_g[i] = 0; m_age[i] = 0;
            m_ptr[i] = 0; m_sel[i] = 0;
        end

        // Reset held two cycles with all requests high, then round-robin.
        req[0] = 4'b1111;
        cyc(); chk_zero("A.rst1", 0);
        cyc(); chk_zero("A.rst2", 0);
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            chk($sformatf("A.gnt%0d", c), gnt[0], 4'(1 << ((c - 1) / 2)));
            chk($sformatf("A.sel%0d", c), {2'b0, sel[0]}, 4'((c - 1) / 2));
            chk($sformatf("A.men%0d", c), {3'b0, mem_en[0]}, 4'(c % 2));
            chk($sformatf("A.ack%0d", c), ack[0],
                (c % 2 == 0) ? 4'(1 << ((c - 1) / 2)) : 4'b0);
            chk($sformatf("A.busy%0d", c), {3'b0, busy[0]}, 4'b1);
            req[0] = req[0] & ~ack[0];
        end
        cyc();
        chk("A.idle.gnt", gnt[0], 4'b0);
        chk("A.idle.busy", {3'b0, busy[0]}, 4'b0);
        chk("A.idle.sel", {2'b0, sel[0]}, 4'd3);

        // Single request from requester 2.
        rst[0] = 1'b1; cyc(); rst[0] = 1'b0;
        req[0] = 4'b0100;
        cyc();
        chk("B.c1.sel", {2'b0, sel[0]}, 4'd2);
        chk("B.c1.gnt", gnt[0], 4'b0100);
        chk("B.c1.men", {3'b0, mem_en[0]}, 4'b1);
        chk("B.c1.busy", {3'b0, busy[0]}, 4'b1);
        cyc();
        chk("B.c2.ack", ack[0], 4'b0100);
        chk("B.c2.men", {3'b0, mem_en[0]}, 4'b0);
        req[0] = 4'b0;
        cyc();
        chk("B.c3.gnt", gnt[0], 4'b0);
        chk("B.c3.busy", {3'b0, busy[0]}, 4'b0);
        chk("B.c3.sel", {2'b0, sel[0]}, 4'd2);
        chk("B.c3.ack", ack[0], 4'b0);

        // Acked requester masked at re-arbitration; pointer advances.
        rst[0] = 1'b1; cyc(); rst[0] = 1'b0;
        req[0] = 4'b0011;
        cyc(); chk("C.c1.gnt", gnt[0], 4'b0001);
        cyc(); chk("C.c2.ack", ack[0], 4'b0001);
        cyc();
        chk("C.c3.gnt", gnt[0], 4'b0010);
        chk("C.c3.men", {3'b0, mem_en[0]}, 4'b1);
        cyc(); chk("C.c4.ack", ack[0], 4'b0010);
        req[0] = 4'b0;
        cyc(); chk("C.c5.busy", {3'b0, busy[0]}, 4'b0);
        req[0] = 4'b0011;
        cyc(); chk("C.ptr2.gnt", gnt[0], 4'b0001);
        req[0] = 4'b0;
        cyc(); cyc();
        chk("C.end.busy", {3'b0, busy[0]}, 4'b0);

        // LAT=3 single transaction.
        rst[1] = 1'b1; cyc(); rst[1] = 1'b0;
        req[1] = 4'b0010;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            chk($sformatf("D.men%0d", c), {3'b0, mem_en[1]}, 4'(c == 1));
            chk($sformatf("D.busy%0d", c), {3'b0, busy[1]}, 4'(c <= 4));
            chk($sformatf("D.ack%0d", c), ack[1],
                (c == 4) ? 4'b0010 : 4'b0);
            req[1] = req[1] & ~ack[1];
        end

        // LAT=4 reset mid-WAIT aborts without ACK; pointer back to 0.
        rst[2] = 1'b1; cyc(); rst[2] = 1'b0;
        req[2] = 4'b0100;
        cyc(); chk("E.c1.gnt", gnt[2], 4'b0100);
        cyc();
        chk("E.c2.busy", {3'b0, busy[2]}, 4'b1);
        chk("E.c2.men", {3'b0, mem_en[2]}, 4'b0);
        rst[2] = 1'b1;
        cyc(); chk_zero("E.rst", 2);
        rst[2] = 1'b0;
        req[2] = 4'b1010;
        cyc();
        chk("E.new.gnt", gnt[2], 4'b0010);
        chk("E.new.sel", {2'b0, sel[2]}, 4'd1);
        chk("E.new.men", {3'b0, mem_en[2]}, 4'b1);
        req[2] = 4'b0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            chk($sformatf("E.noack%0d", c), ack[2] & 4'b0100, 4'b0);
        end
        chk("E.end.busy", {3'b0, busy[2]}, 4'b0);

        // Random traffic, occasional early drops and resets.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 3; i++) begin
                req[i] = req[i] & ~ack[i];
                if ($urandom_range(0, 15) == 0)
                    req[i][$urandom_range(0, 3)] = 1'b0;
                req[i] = req[i] | (4'($urandom) & 4'($urandom));
                rst[i] = ($urandom_range(0, 79) == 0);
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 Parameter: LAT, default 1, fixed memory latency in cycles from the MEM_EN cycle to the data-valid/ACK cycle; legal range 1..8.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 REQ  in  4  per-requester request; bit i = requester i; held high until that requester's ACK.
REQ-005 SEL  out 2  select for the downstream 4:1 address/data mux; encoded index of the current grantee.
REQ-006 GNT  out 4  one-hot grant, held for the whole transaction.
REQ-007 MEM_EN  out 1  memory strobe, exactly one cycle per transaction.
REQ-008 ACK  out 4  one-hot completion pulse, one cycle, to the grantee.
REQ-009 BUSY  out 1  high while a transaction is outstanding.

Function
REQ-010 FSM states: IDLE, ISSUE, WAIT; all outputs driven from registers, no combinational REQ-to-output path.
REQ-011 IDLE with REQ!=0 -> ISSUE next cycle; IDLE with REQ==0 -> stay IDLE.
REQ-012 Arbitration is round-robin: search order PTR, PTR+1, PTR+2, PTR+3 (mod 4); first set REQ bit wins.
REQ-013 On winner i latched: GNT=onehot(i), SEL=i, PTR=(i+1) mod 4.
REQ-014 ISSUE (one cycle): MEM_EN=1, BUSY=1, latency counter (4 bits) loaded with LAT; next state WAIT.
REQ-015 WAIT: MEM_EN=0, BUSY=1; counter decrements each cycle; ACK=GNT in the cycle LAT cycles after the MEM_EN cycle.
REQ-016 In the ACK cycle, re-arbitrate over REQ with the acked bit masked; winner present -> ISSUE next cycle (back-to-back, no idle bubble); none -> IDLE.
REQ-017 With REQ continuously 4'b1111, throughput is one transaction per LAT+1 cycles.
REQ-018 GNT clears to 0 on the transition to IDLE; SEL retains its last value in IDLE.
REQ-019 REQ changes during ISSUE/WAIT are ignored; early deassertion of the grantee's REQ does not abort the transaction; ACK still pulses.
REQ-020 REQ rising during a transaction is served only at the next arbitration point (ACK cycle or IDLE).
REQ-021 ACK and MEM_EN are never high in the same cycle; ACK is never multi-hot.
REQ-022 LAT outside 1..8 is a configuration error; behaviour is unspecified and is flagged by an elaboration-time check.

Reset
REQ-023 RST high at a clock edge -> state IDLE, PTR=0, SEL=0, GNT=0, MEM_EN=0, ACK=0, BUSY=0, counter=0.
REQ-024 RST overrides everything, including mid-ISSUE/WAIT; the aborted transaction produces no ACK.
REQ-025 REQ is not sampled in any cycle where RST is high; arbitration resumes the first edge after RST falls.

Verification (LAT=1 unless stated; cycle 0 = first edge with RST low)
REQ-026 RST held 2 cycles with REQ=4'b1111 -> all outputs 0 throughout; cycle 1: GNT=0001, SEL=0, MEM_EN=1.
REQ-027 Idle, REQ=0100 at cycle 0 -> cycle 1 SEL=2, GNT=0100, MEM_EN=1, BUSY=1; cycle 2 ACK=0100; cycle 3 GNT=0, BUSY=0, SEL=2.
REQ-028 REQ=1111 held, requesters drop after their ACK -> grant order 0,1,2,3; MEM_EN on cycles 1,3,5,7; ACK on 2,4,6,8; no idle cycle between.
REQ-029 LAT=3, REQ=0010 -> MEM_EN at cycle 1 only, ACK=0010 at cycle 4, BUSY high cycles 1..4, low at 5.
REQ-030 REQ=0011 in ACK cycle for requester 0 (REQ[0] still high) -> next grant is 0010, not 0001; PTR=2 afterwards.
REQ-031 RST pulsed in WAIT with LAT=4 -> next cycle all outputs 0, no ACK ever issued for that transaction, next grant starts from PTR=0.
